// File: rtl/max7219_msg_loader_if.sv
// Bundle between the message loader and its environment: character
// stream in, font ROM lookup, scroller RAM write port and scroller control.
// The "master" side is the environment; the loader uses the "slave" side.
interface max7219_msg_loader_if #(
  parameter int G_RAM_ADDR_WIDTH  = 8,
  parameter int G_RAM_DATA_WIDTH  = 8,
  parameter int G_FONT_ADDR_WIDTH = 11
);
  // character stream
  logic                         i_char_valid;
  logic [7:0]                   i_char;
  logic                         i_char_last;
  logic                         o_char_ready;
  // font ROM (registered read, one cycle latency)
  logic [G_FONT_ADDR_WIDTH-1:0] o_font_addr;
  logic [G_RAM_DATA_WIDTH-1:0]  i_font_data;
  // scroller
  logic                         i_scroller_busy;
  logic                         o_me;
  logic                         o_we;
  logic [G_RAM_ADDR_WIDTH-1:0]  o_addr;
  logic [G_RAM_DATA_WIDTH-1:0]  o_wdata;
  logic [G_RAM_ADDR_WIDTH-1:0]  o_ram_start_ptr;
  logic [7:0]                   o_msg_length;
  logic                         o_start_scroll;
  // status
  logic                         o_busy;
  logic                         o_overflow;

  modport master (
    output i_char_valid, i_char, i_char_last, i_font_data, i_scroller_busy,
    input  o_char_ready, o_font_addr, o_me, o_we, o_addr, o_wdata,
           o_ram_start_ptr, o_msg_length, o_start_scroll, o_busy, o_overflow
  );

  modport slave (
    input  i_char_valid, i_char, i_char_last, i_font_data, i_scroller_busy,
    output o_char_ready, o_font_addr, o_me, o_we, o_addr, o_wdata,
           o_ram_start_ptr, o_msg_length, o_start_scroll, o_busy, o_overflow
  );
endinterface

// File: rtl/max7219_msg_loader.sv
// Message loader: takes ASCII characters, looks each one up column by
// column in an external font ROM and streams the column bytes into the
// scroller RAM, then kicks the scroller with the message start/length.
module max7219_msg_loader #(
  parameter int G_RAM_ADDR_WIDTH = 8,
  parameter int G_RAM_DATA_WIDTH = 8,
  parameter int G_COLS_PER_CHAR  = 8,
  parameter int G_RAM_BASE       = 0,
  parameter int G_MAX_CHARS      = 31
) (
  input logic                    clk,
  input logic                    rst,
  max7219_msg_loader_if.slave    bus
);

  localparam int COL_W    = (G_COLS_PER_CHAR > 1) ? $clog2(G_COLS_PER_CHAR) : 1;
  localparam int MAX_COLS = G_COLS_PER_CHAR * G_MAX_CHARS;

  localparam logic [7:0]                  COLS8      = 8'(G_COLS_PER_CHAR);
  localparam logic [7:0]                  MAX_COLS8  = 8'(MAX_COLS);
  localparam logic [COL_W:0]              PHASE_LAST = (COL_W + 1)'(G_COLS_PER_CHAR);
  localparam logic [G_RAM_ADDR_WIDTH-1:0] BASE       = G_RAM_ADDR_WIDTH'(G_RAM_BASE);
  localparam logic [G_RAM_ADDR_WIDTH-1:0] COLS_A     = G_RAM_ADDR_WIDTH'(G_COLS_PER_CHAR);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_START} state_t;

  state_t                      state_q, state_d;
  logic [7:0]                  char_q, char_d;
  logic                        last_q, last_d;
  logic                        drop_q, drop_d;       // current char exceeds capacity
  logic                        first_q, first_d;     // next accepted char opens a message
  logic                        overflow_q, overflow_d;
  logic [G_RAM_ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [7:0]                  count_q, count_d;     // columns stored in current message
  logic [7:0]                  msg_length_q, msg_length_d;
  logic [COL_W:0]              phase_q, phase_d;     // 0..G_COLS_PER_CHAR within LOAD

  logic                        char_ready;
  logic                        accept;
  logic [7:0]                  count_base;
  logic [8+COL_W-1:0]          font_addr;
  logic                        ram_wr;
  logic [G_RAM_ADDR_WIDTH-1:0] ram_addr;
  logic [G_RAM_DATA_WIDTH-1:0] ram_wdata;
  logic                        start_scroll;

  // The scroller may only be kept waiting on the first char of a message;
  // later chars of the same message go in regardless of its busy flag.
  assign char_ready = !rst && (state_q == S_IDLE) && (!first_q || !bus.i_scroller_busy);
  assign accept     = char_ready && bus.i_char_valid;

  // Next-state and output decode: LOAD phase p requests column p and
  // writes column p-1 (ROM data arrives one cycle after its address).
  always_comb begin
    state_d      = state_q;
    char_d       = char_q;
    last_d       = last_q;
    drop_d       = drop_q;
    first_d      = first_q;
    overflow_d   = overflow_q;
    ptr_d        = ptr_q;
    count_d      = count_q;
    msg_length_d = msg_length_q;
    phase_d      = phase_q;
    count_base   = count_q;
    font_addr    = '0;
    ram_wr       = 1'b0;
    ram_addr     = '0;
    ram_wdata    = '0;
    start_scroll = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          char_d  = bus.i_char;
          last_d  = bus.i_char_last;
          phase_d = '0;
          first_d = 1'b0;
          state_d = S_LOAD;
          if (first_q) begin
            overflow_d = 1'b0;
            ptr_d      = BASE;
            count_base = 8'd0;
          end
          count_d = count_base;
          drop_d  = (count_base >= MAX_COLS8);
          if (count_base >= MAX_COLS8) begin
            overflow_d = 1'b1;
          end
        end
      end

      S_LOAD: begin
        if (drop_q) begin
          // No room left: skip the font/RAM traffic entirely.
          if (last_q) begin
            msg_length_d = count_q;
            state_d      = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          if (phase_q != PHASE_LAST) begin
            font_addr = {char_q, phase_q[COL_W-1:0]};
          end
          if (phase_q != '0) begin
            ram_wr    = 1'b1;
            ram_addr  = ptr_q + G_RAM_ADDR_WIDTH'(phase_q - 1'b1);
            ram_wdata = G_RAM_DATA_WIDTH'(bus.i_font_data);
          end
          if (phase_q == PHASE_LAST) begin
            ptr_d   = ptr_q + COLS_A;
            count_d = count_q + COLS8;
            if (last_q) begin
              msg_length_d = count_q + COLS8;
              state_d      = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end

      S_START: begin
        start_scroll = 1'b1;
        first_d      = 1'b1;
        state_d      = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset abandons any partial message on the spot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      char_q       <= '0;
      last_q       <= 1'b0;
      drop_q       <= 1'b0;
      first_q      <= 1'b1;
      overflow_q   <= 1'b0;
      ptr_q        <= BASE;
      count_q      <= '0;
      msg_length_q <= '0;
      phase_q      <= '0;
    end else begin
      state_q      <= state_d;
      char_q       <= char_d;
      last_q       <= last_d;
      drop_q       <= drop_d;
      first_q      <= first_d;
      overflow_q   <= overflow_d;
      ptr_q        <= ptr_d;
      count_q      <= count_d;
      msg_length_q <= msg_length_d;
      phase_q      <= phase_d;
    end
  end

  assign bus.o_char_ready    = char_ready;
  assign bus.o_font_addr     = font_addr;
  assign bus.o_me            = ram_wr;
  assign bus.o_we            = ram_wr;
  assign bus.o_addr          = ram_addr;
  assign bus.o_wdata         = ram_wdata;
  assign bus.o_ram_start_ptr = BASE;
  assign bus.o_msg_length    = msg_length_q;
  assign bus.o_start_scroll  = start_scroll;
  assign bus.o_busy          = (state_q != S_IDLE);
  assign bus.o_overflow      = overflow_q;

endmodule

// File: tb/tb_max7219_msg_loader.sv
// Scoreboard bench for max7219_msg_loader: the driver pushes expected RAM
// writes and start pulses (with their cycle numbers) derived from the
// character stream; a negedge monitor pops and compares them.
module tb_max7219_msg_loader;
  localparam int G    = 8;
  localparam int MAXC = 31;
  localparam int BASE = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  max7219_msg_loader_if bus ();

  max7219_msg_loader #(
    .G_RAM_ADDR_WIDTH(8), .G_RAM_DATA_WIDTH(8), .G_COLS_PER_CHAR(G),
    .G_RAM_BASE(BASE), .G_MAX_CHARS(MAXC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Font ROM contents: an arbitrary scramble of the address.
  function automatic logic [7:0] rom_f(input logic [10:0] a);
    logic [31:0] t;
    t = a * 157 + (a >> 3);
    return t[7:0] ^ 8'h5A;
  endfunction

  always @(posedge clk) bus.i_font_data <= rom_f(bus.o_font_addr);

  // busy_mode: 0 = idle scroller, 1 = busy scroller, 2 = random toggling
  int busy_mode = 0;
  initial begin
    bus.i_scroller_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (busy_mode)
        1:       bus.i_scroller_busy = 1'b1;
        2:       bus.i_scroller_busy = 1'($urandom_range(0, 1));
        default: bus.i_scroller_busy = 1'b0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  typedef struct { int cyc; logic [7:0] addr; logic [7:0] data; } wr_t;
  typedef struct { int cyc; logic [7:0] len; logic ovf; } st_t;
  wr_t wq[$];
  st_t sq[$];
  wr_t mw;
  st_t ms;

  // Monitor: every RAM write and start pulse must match the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_me || bus.o_we) begin
        if (wq.size() == 0) begin
          chk("unexpected_write_addr", {24'd0, bus.o_addr}, 32'hFFFF_FFFF);
        end else begin
          mw = wq.pop_front();
          chk("wr_strobes", {30'd0, bus.o_me, bus.o_we}, 32'd3);
          chk("wr_cycle", cyc, mw.cyc);
          chk("wr_addr", {24'd0, bus.o_addr}, {24'd0, mw.addr});
          chk("wr_data", {24'd0, bus.o_wdata}, {24'd0, mw.data});
          $display("write cyc=%0d addr=%0d data=0x%02h", cyc, bus.o_addr, bus.o_wdata);
        end
      end else begin
        chk("idle_ram_bus", {16'd0, bus.o_addr, bus.o_wdata}, 32'd0);
      end
      if (bus.o_start_scroll) begin
        if (sq.size() == 0) begin
          chk("unexpected_start_len", {24'd0, bus.o_msg_length}, 32'hFFFF_FFFF);
        end else begin
          ms = sq.pop_front();
          chk("start_cycle", cyc, ms.cyc);
          chk("start_len", {24'd0, bus.o_msg_length}, {24'd0, ms.len});
          chk("start_ptr", {24'd0, bus.o_ram_start_ptr}, BASE);
          chk("start_ovf", {31'd0, bus.o_overflow}, {31'd0, ms.ovf});
          $display("start cyc=%0d len=%0d ovf=%0d", cyc, bus.o_msg_length, bus.o_overflow);
        end
      end
    end
  end

  // Reference model of the message being assembled.
  bit         m_first    = 1'b1;
  int         m_cols     = 0;
  int         m_chars    = 0;
  bit         m_ovf      = 1'b0;
  logic [7:0] last_len   = 8'd0;
  int         exp_ready  = 0;

  task automatic send(input logic [7:0] c, input bit last, output int t_acc);
    int waited;
    int issue;
    int nr;
    logic [10:0] fa;
    waited = 0;
    bus.i_char_valid = 1'b1;
    bus.i_char       = c;
    bus.i_char_last  = last;
    @(negedge clk);
    issue = cyc;
    while (!bus.o_char_ready && waited < 3000) begin
      waited++;
      @(negedge clk);
    end
    if (!bus.o_char_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: char 0x%02h never accepted, ready=%0d expected 1", c, bus.o_char_ready);
      bus.i_char_valid = 1'b0;
      t_acc = -1;
      return;
    end
    t_acc = cyc;
    if (m_first) begin
      chk("msg_len_hold", {24'd0, bus.o_msg_length}, {24'd0, last_len});
      m_first = 1'b0;
      m_cols  = 0;
      m_chars = 0;
      m_ovf   = 1'b0;
    end else begin
      chk("accept_cycle", t_acc, (issue > exp_ready) ? issue : exp_ready);
    end
    if (m_chars < MAXC) begin
      for (int k = 0; k < G; k++) begin
        fa = {c, 3'(k)};
        wq.push_back('{t_acc + 2 + k, 8'(BASE + m_cols + k), rom_f(fa)});
      end
      m_cols += G;
      nr = t_acc + G + 2;
    end else begin
      m_ovf = 1'b1;
      nr = t_acc + 2;
    end
    m_chars++;
    exp_ready = nr;
    if (last) begin
      sq.push_back('{nr, 8'(m_cols), m_ovf});
      last_len = 8'(m_cols);
      m_first  = 1'b1;
    end
    $display("accept cyc=%0d char=0x%02h last=%0d", t_acc, c, last);
    @(posedge clk);
    #1;
    chk("busy_after_accept", {30'd0, bus.o_busy, bus.o_char_ready}, 32'd2);
    bus.i_char_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctl"}, {26'd0, bus.o_char_ready, bus.o_me, bus.o_we, bus.o_start_scroll,
                        bus.o_busy, bus.o_overflow}, 32'd0);
    chk({tag, "_bus"}, {5'd0, bus.o_font_addr, bus.o_addr, bus.o_wdata}, 32'd0);
    chk({tag, "_len_ptr"}, {16'd0, bus.o_msg_length, bus.o_ram_start_ptr}, BASE);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  int t;
  int t_fall;
  int nchars;
  string hi;

  initial begin
    bus.i_char_valid = 1'b0;
    bus.i_char       = 8'd0;
    bus.i_char_last  = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset_state");
    rst = 1'b0;
    @(posedge clk);
    #2;

    // a) single char, scroller idle
    send(8'h41, 1'b1, t);
    repeat (12) @(posedge clk);
    #2;

    // b) "HI" back-to-back
    hi = "HI";
    send(hi[0], 1'b0, t);
    send(hi[1], 1'b1, t);
    repeat (12) @(posedge clk);
    #2;

    // c) scroller busy holds off the first char
    busy_mode = 1;
    @(posedge clk);
    #2;
    bus.i_char_valid = 1'b1;
    bus.i_char       = 8'h43;
    bus.i_char_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("ready_while_busy", {31'd0, bus.o_char_ready}, 32'd0);
    end
    busy_mode = 0;
    @(posedge clk);
    #2;
    t_fall = cyc;
    send(8'h43, 1'b1, t);
    chk("accept_after_busy_fall", t, t_fall);
    repeat (12) @(posedge clk);
    #2;

    // d) 33 chars: overflow, then a fresh message clears it
    for (int i = 0; i < 33; i++) begin
      send(8'($urandom_range(32, 126)), (i == 32), t);
    end
    #1;
    chk("overflow_sticky", {31'd0, bus.o_overflow}, 32'd1);
    repeat (12) @(posedge clk);
    #2;
    send(8'h5A, 1'b1, t);
    #1;
    chk("overflow_cleared", {31'd0, bus.o_overflow}, 32'd0);
    repeat (12) @(posedge clk);
    #2;

    // e) reset during column 3 of the second char
    send(8'h31, 1'b0, t);
    send(8'h32, 1'b0, t);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_mid_load");
    wq.delete();
    sq.delete();
    m_first  = 1'b1;
    last_len = 8'd0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    send(8'h33, 1'b1, t);
    repeat (12) @(posedge clk);
    #2;

    // f) + random: random messages with a randomly toggling scroller busy;
    // valid is held across LOAD by back-to-back sends.
    busy_mode = 2;
    for (int m = 0; m < 20; m++) begin
      nchars = $urandom_range(1, 6);
      for (int i = 0; i < nchars; i++) begin
        send(8'($urandom), (i == nchars - 1), t);
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 5)) @(posedge clk);
          #2;
        end
      end
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #2;
    end
    busy_mode = 0;

    repeat (30) @(posedge clk);
    #2;
    chk("writes_pending", wq.size(), 0);
    chk("starts_pending", sq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
